ml_cmd_ctrl: RTL and testbench
==============================

// Module: ml_cmd_ctrl
// PURPOSE
//  Command sequencer behind the ML host nibble-serial receiver. Consumes the
//  byte stream (din_valid/din_data) plus frame start/end strobes derived from
//  ml_csb, decodes a command byte, loads a 16-bit start address, streams
//  payload bytes into data or coefficient memory, kicks the compute engine
//  and drives the host-visible ml_rdy / ml_err status pins.
// PARAMETERS
//  ADDR_BITS  16  memory address width; received address truncated to low bits
// PORTS
//  clock        in   1          system clock, all logic posedge
//  reset        in   1          asynchronous, active-high
//  frame_start  in   1          1-cycle pulse, ml_csb falling (synchronised)
//  frame_end    in   1          1-cycle pulse, ml_csb rising (synchronised)
//  din_valid    in   1          1-cycle pulse, din_data holds a full byte
//  din_data     in   8          received byte
//  comp_busy    in   1          compute engine running
//  comp_start   out  1          1-cycle pulse, launch compute
//  mem_sel      out  1          0 = data memory, 1 = coefficient memory
//  mem_addr     out  ADDR_BITS  write address
//  mem_wdata    out  8          write data
//  mem_wen      out  1          1-cycle write strobe
//  ml_rdy       out  1          host ready: no compute busy/pending
//  ml_err       out  1          sticky error flag
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; addr 0; err_flag 0.
//  - States: IDLE, CMD, ADDR_HI, ADDR_LO, DATA, SKIP.
//  - frame_start in any state -> CMD (aborts open transfer, no error).
//  - frame_end: -> IDLE; if state ADDR_HI/ADDR_LO, set err_flag (short hdr).
//  - din_valid in IDLE (no frame) ignored.
//  - CMD on din_valid:
//      8'h21 WR_DATA -> mem_sel<=0, ADDR_HI
//      8'h22 WR_COEF -> mem_sel<=1, ADDR_HI
//      8'h30 RUN     -> comp_busy|pending ? err_flag<=1 : comp_start pulse; SKIP
//      8'h40 CLR_ERR -> err_flag<=0; SKIP
//      other         -> err_flag<=1; SKIP
//  - ADDR_HI: addr[15:8]<=byte; ADDR_LO: addr[7:0]<=byte -> DATA.
//  - DATA: per din_valid, next cycle mem_wen=1, mem_addr=addr, mem_wdata=byte;
//    addr+1 mod 2^ADDR_BITS (wrap silent, no error). Latency 1 cycle.
//  - SKIP: bytes discarded until frame_end / frame_start.
//  - Same-cycle frame_end + din_valid: byte processed first, then IDLE.
//    Same-cycle frame_start + din_valid: frame_start wins, byte dropped.
//  - comp_start asserted 1 cycle after RUN byte; pending flag set with it,
//    cleared when comp_busy seen high. ml_rdy = registered !(comp_busy|pending);
//    low in the cycle after RUN accepted, high 1 cycle after comp_busy falls.
//  - ml_err = err_flag, registered; sticky until CLR_ERR or reset.
//  - Reset mid-frame: everything to reset values; no partial write issued.
// STRUCTURE
//  - ml_defs.vh: command codes (CMD_WR_DATA/WR_COEF/RUN/CLR_ERR), state codes.
//  - Single module; no sub-module (decoder + address counter are inline).
// TESTING
//  - frame, 21 01 00 AA BB CC, end -> wen x3 at addr 0x0100..0x0102,
//    data AA/BB/CC, mem_sel 0, ml_err 0.
//  - 22 FF FF 11 22 with ADDR_BITS=16 -> writes 0xFFFF=11, 0x0000=22,
//    mem_sel 1, no error.
//  - 30 with comp_busy low -> one comp_start pulse, ml_rdy 0 until busy
//    rises/falls; second 30 while busy -> no pulse, ml_err 1.
//  - frame 55 -> ml_err 1; frame 40 -> ml_err 0; no mem_wen in either.
//  - frame 21 01, frame_end -> ml_err 1, no wen; new frame_start mid-DATA
//    then 21 00 10 77 -> single write 0x0010=77.
//  - reset asserted mid-DATA -> all outputs 0 immediately, state IDLE,
//    following bytes ignored until frame_start.

Source files
------------

// File: rtl/ml_cmd_ctrl_pkg.sv
// ml_cmd_ctrl_pkg: command codes, sequencer states and small helpers shared by the ML command controller.
package ml_cmd_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_SKIP
    } state_t;
    localparam logic [7:0] CMD_WR_DATA = 8'h21;
    localparam logic [7:0] CMD_WR_COEF = 8'h22;
    localparam logic [7:0] CMD_RUN     = 8'h30;
    localparam logic [7:0] CMD_CLR_ERR = 8'h40;
    function automatic logic is_hdr(input state_t s);
        return s == S_ADDR_HI || s == S_ADDR_LO;
    endfunction
    function automatic logic is_wr(input logic [7:0] c);
        return c == CMD_WR_DATA || c == CMD_WR_COEF;
    endfunction
endpackage

// File: rtl/ml_cmd_ctrl.sv
// ml_cmd_ctrl: frame/byte command sequencer that loads an address, streams payload
// into data or coefficient memory, launches compute and reports ready/error status.
module ml_cmd_ctrl
    import ml_cmd_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_frame_start,
    input  logic                 i_frame_end,
    input  logic                 i_din_valid,
    input  logic [7:0]           i_din_data,
    input  logic                 i_comp_busy,
    output logic                 o_comp_start,
    output logic                 o_mem_sel,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [7:0]           o_mem_wdata,
    output logic                 o_mem_wen,
    output logic                 o_ml_rdy,
    output logic                 o_ml_err
);
    state_t                r_state;
    logic [7:0]            r_addr_hi;
    logic [ADDR_BITS-1:0]  r_addr;
    logic                  r_pending;
    logic                  r_err;
    logic                  r_comp_start;
    logic                  r_mem_sel;
    logic [ADDR_BITS-1:0]  r_mem_addr;
    logic [7:0]            r_mem_wdata;
    logic                  r_mem_wen;
    logic                  r_rdy;
    state_t                w_next;
    logic                  w_byte;
    logic                  w_run_go;
    logic                  w_err_set;
    logic                  w_err_clr;
    logic                  w_hdr_cut;

    // frame_start beats a same-cycle byte, so the byte is never seen
    assign w_byte = i_din_valid & ~i_frame_start;

    always_comb begin
        w_next    = r_state;
        w_run_go  = 1'b0;
        w_err_set = 1'b0;
        w_err_clr = 1'b0;
        if (w_byte) begin
            case (r_state)
                S_CMD: begin
                    w_next    = is_wr(i_din_data) ? S_ADDR_HI : S_SKIP;
                    w_run_go  = i_din_data == CMD_RUN && !(i_comp_busy || r_pending);
                    w_err_set = i_din_data == CMD_RUN ? (i_comp_busy || r_pending)
                                                      : !(is_wr(i_din_data) || i_din_data == CMD_CLR_ERR);
                    w_err_clr = i_din_data == CMD_CLR_ERR;
                end
                S_ADDR_HI: w_next = S_ADDR_LO;
                S_ADDR_LO: w_next = S_DATA;
                default:   w_next = r_state;
            endcase
        end
    end

    // a frame that closes before the address is complete is a short header
    assign w_hdr_cut = i_frame_end & ~i_frame_start & is_hdr(w_next);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_addr_hi    <= '0;
            r_addr       <= '0;
            r_pending    <= 1'b0;
            r_err        <= 1'b0;
            r_comp_start <= 1'b0;
            r_mem_sel    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wen    <= 1'b0;
            r_rdy        <= 1'b0;
        end else begin
            r_comp_start <= w_run_go;
            r_pending    <= w_run_go | (r_pending & ~i_comp_busy);
            r_rdy        <= ~(i_comp_busy | r_pending | w_run_go);
            r_err        <= (w_err_set | w_hdr_cut) ? 1'b1 : w_err_clr ? 1'b0 : r_err;
            r_mem_wen    <= 1'b0;
            r_state      <= i_frame_start ? S_CMD : i_frame_end ? S_IDLE : w_next;
            if (w_byte && r_state == S_CMD && is_wr(i_din_data))
                r_mem_sel <= i_din_data == CMD_WR_COEF;
            if (w_byte && r_state == S_ADDR_HI)
                r_addr_hi <= i_din_data;
            if (w_byte && r_state == S_ADDR_LO)
                r_addr <= ADDR_BITS'({r_addr_hi, i_din_data});
            if (w_byte && r_state == S_DATA) begin
                r_mem_wen   <= 1'b1;
                r_mem_addr  <= r_addr;
                r_mem_wdata <= i_din_data;
                r_addr      <= r_addr + ADDR_BITS'(1);
            end
        end
    end

    assign o_comp_start = r_comp_start;
    assign o_mem_sel    = r_mem_sel;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_wen    = r_mem_wen;
    assign o_ml_rdy     = r_rdy;
    assign o_ml_err     = r_err;
endmodule

// File: tb/tb_ml_cmd_ctrl.sv
// tb_ml_cmd_ctrl: directed and randomized frames checked against a frame-level model of the command controller.
module tb_ml_cmd_ctrl;
    typedef struct packed {
        logic        sel;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 0, rst = 1, fs = 0, fe = 0, dv = 0, busy = 0;
    logic [7:0]  dd = 0;
    logic        comp_start, mem_sel, mem_wen, ml_rdy, ml_err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    int          n_checks = 0, n_err = 0, n_start = 0;
    wr_t         got_q[$], exp_q[$];
    logic        exp_err = 0;

    always #5 clk = ~clk;

    ml_cmd_ctrl #(.ADDR_BITS(16)) dut (
        .i_clock(clk), .i_reset(rst), .i_frame_start(fs), .i_frame_end(fe),
        .i_din_valid(dv), .i_din_data(dd), .i_comp_busy(busy),
        .o_comp_start(comp_start), .o_mem_sel(mem_sel), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_wen(mem_wen), .o_ml_rdy(ml_rdy), .o_ml_err(ml_err)
    );

    always @(negedge clk) begin
        if (mem_wen) got_q.push_back('{mem_sel, mem_addr, mem_wdata});
        if (comp_start) n_start++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fstart();
        fs = 1; @(negedge clk); fs = 0;
    endtask

    task automatic fend();
        fe = 1; @(negedge clk); fe = 0; tick(2);
    endtask

    task automatic send(input logic [7:0] b);
        dv = 1; dd = b; @(negedge clk); dv = 0;
    endtask

    task automatic test_reset();
        tick(2);
        n_checks++;
        if ({comp_start, mem_sel, mem_addr, mem_wdata, mem_wen, ml_rdy, ml_err} !== '0) begin
            n_err++; $display("FAIL reset_outputs got %h required 0",
                {comp_start, mem_sel, mem_addr, mem_wdata, mem_wen, ml_rdy, ml_err});
        end
        rst = 0; tick(2);
        n_checks++;
        if (ml_rdy !== 1'b1 || ml_err !== 1'b0) begin
            n_err++; $display("FAIL post_reset rdy/err got %b%b required 10", ml_rdy, ml_err);
        end
    endtask

    task automatic test_data_write();
        got_q.delete(); exp_q.delete();
        exp_q.push_back('{1'b0, 16'h0100, 8'hAA});
        exp_q.push_back('{1'b0, 16'h0101, 8'hBB});
        exp_q.push_back('{1'b0, 16'h0102, 8'hCC});
        fstart();
        foreach (exp_q[i]) if (i == 0) begin send(8'h21); send(8'h01); send(8'h00); send(exp_q[i].data); end else send(exp_q[i].data);
        fend();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL data_write count got %0d required %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL data_write[%0d] got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (ml_err !== 1'b0) begin n_err++; $display("FAIL data_write err got %b required 0", ml_err); end
    endtask

    task automatic test_wrap();
        got_q.delete(); exp_q.delete();
        exp_q.push_back('{1'b1, 16'hFFFF, 8'h11});
        exp_q.push_back('{1'b1, 16'h0000, 8'h22});
        fstart(); send(8'h22); send(8'hFF); send(8'hFF); send(8'h11); send(8'h22); fend();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL wrap count got %0d required %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL wrap[%0d] got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (ml_err !== 1'b0) begin n_err++; $display("FAIL wrap err got %b required 0", ml_err); end
    endtask

    task automatic test_run();
        int s0;
        s0 = n_start;
        fstart(); send(8'h30);
        n_checks++;
        if (comp_start !== 1'b1 || ml_rdy !== 1'b0) begin
            n_err++; $display("FAIL run_launch start/rdy got %b%b required 10", comp_start, ml_rdy);
        end
        fend(); tick(3);
        n_checks++;
        if (n_start != s0 + 1 || ml_rdy !== 1'b0) begin
            n_err++; $display("FAIL run_pending starts/rdy got %0d/%b required %0d/0", n_start - s0, ml_rdy, 1);
        end
        busy = 1; tick(3);
        fstart(); send(8'h30); fend();
        n_checks++;
        if (n_start != s0 + 1 || ml_err !== 1'b1 || ml_rdy !== 1'b0) begin
            n_err++; $display("FAIL run_busy starts/err/rdy got %0d/%b/%b required 1/1/0", n_start - s0, ml_err, ml_rdy);
        end
        busy = 0; tick(2);
        n_checks++;
        if (ml_rdy !== 1'b1) begin n_err++; $display("FAIL run_done rdy got %b required 1", ml_rdy); end
        fstart(); send(8'h40); fend();
    endtask

    task automatic test_errors();
        got_q.delete();
        fstart(); send(8'h55); fend();
        n_checks++;
        if (ml_err !== 1'b1) begin n_err++; $display("FAIL bad_cmd err got %b required 1", ml_err); end
        fstart(); send(8'h40); fend();
        n_checks++;
        if (ml_err !== 1'b0) begin n_err++; $display("FAIL clr_err err got %b required 0", ml_err); end
        n_checks++;
        if (got_q.size() != 0) begin n_err++; $display("FAIL err_frames wen count got %0d required 0", got_q.size()); end
    endtask

    task automatic test_short_hdr();
        got_q.delete();
        fstart(); send(8'h21); send(8'h01); fend();
        n_checks++;
        if (ml_err !== 1'b1 || got_q.size() != 0) begin
            n_err++; $display("FAIL short_hdr err/wen got %b/%0d required 1/0", ml_err, got_q.size());
        end
        fstart(); send(8'h40); fend();
        fstart(); send(8'h21); send(8'h01); send(8'h00);
        fstart(); send(8'h21); send(8'h00); send(8'h10); send(8'h77); fend();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== '{1'b0, 16'h0010, 8'h77}) begin
            n_err++; $display("FAIL restart writes got n=%0d first=%h required n=1 %h", got_q.size(),
                got_q.size() ? got_q[0] : wr_t'(0), wr_t'({1'b0, 16'h0010, 8'h77}));
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        fstart(); send(8'h21); send(8'h00); send(8'h05);
        dv = 1; dd = 8'h5A; fe = 1; @(negedge clk); dv = 0; fe = 0; tick(2);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== '{1'b0, 16'h0005, 8'h5A}) begin
            n_err++; $display("FAIL end_with_byte n=%0d first=%h required n=1 %h", got_q.size(),
                got_q.size() ? got_q[0] : wr_t'(0), wr_t'({1'b0, 16'h0005, 8'h5A}));
        end
        got_q.delete();
        fstart(); send(8'h21); send(8'h00); send(8'h06);
        dv = 1; dd = 8'h99; fs = 1; @(negedge clk); dv = 0; fs = 0;
        send(8'h21); send(8'h00); send(8'h07); send(8'h33); fend();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== '{1'b0, 16'h0007, 8'h33} || ml_err !== 1'b0) begin
            n_err++; $display("FAIL start_with_byte n=%0d err=%b required n=1 err=0", got_q.size(), ml_err);
        end
    endtask

    task automatic test_reset_mid();
        fstart(); send(8'h22); send(8'h12); send(8'h34); send(8'hAA); tick(1);
        got_q.delete();
        dv = 1; dd = 8'hBB; #1 rst = 1; #1;
        n_checks++;
        if ({comp_start, mem_sel, mem_addr, mem_wdata, mem_wen, ml_rdy, ml_err} !== '0) begin
            n_err++; $display("FAIL reset_mid outputs got %h required 0",
                {comp_start, mem_sel, mem_addr, mem_wdata, mem_wen, ml_rdy, ml_err});
        end
        @(negedge clk); dv = 0; tick(1); rst = 0; tick(2);
        send(8'h55); send(8'h21); send(8'h00); send(8'h00); send(8'h66); tick(2);
        n_checks++;
        if (got_q.size() != 0 || ml_err !== 1'b0) begin
            n_err++; $display("FAIL reset_mid ignore wen/err got %0d/%b required 0/0", got_q.size(), ml_err);
        end
        exp_err = 0;
    endtask

    task automatic test_random();
        logic [7:0]  b[$];
        logic [15:0] base;
        int          n;
        for (int f = 0; f < 40; f++) begin
            b.delete(); got_q.delete(); exp_q.delete();
            n = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            if (n > 0) begin
                case ($urandom_range(0, 3))
                    0: b[0] = 8'h21;
                    1: b[0] = 8'h22;
                    2: b[0] = 8'h40;
                    default: while (b[0] == 8'h21 || b[0] == 8'h22 || b[0] == 8'h30 || b[0] == 8'h40) b[0] = 8'($urandom);
                endcase
                if (b[0] == 8'h21 || b[0] == 8'h22) begin
                    if (n < 3) exp_err = 1;
                    else begin
                        base = {b[1], b[2]};
                        for (int i = 3; i < n; i++) exp_q.push_back('{b[0] == 8'h22, base + 16'(i - 3), b[i]});
                    end
                end else exp_err = (b[0] == 8'h40) ? 1'b0 : 1'b1;
            end
            fstart();
            foreach (b[i]) begin send(b[i]); tick($urandom_range(0, 2)); end
            fend();
            n_checks++;
            if (got_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL rand[%0d] count got %0d required %0d", f, got_q.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL rand[%0d] wr[%0d] got %h required %h", f, i, got_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (ml_err !== exp_err) begin n_err++; $display("FAIL rand[%0d] err got %b required %b", f, ml_err, exp_err); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_data_write();
        test_wrap();
        test_run();
        test_errors();
        test_short_hdr();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
